bus_timer: RTL
==============

// Module: bus_timer
// PURPOSE
//  Memory-mapped 16-bit programmable interval timer on the CPU data bus.
//  Sits downstream of the top-level address switch at 0x0014-0x0017.
//  Consumes addr_bus-20'h14, ram_in and the decoded write strobe. Returns
//  read data for ram_out and drives one irq_ctrl source line (bit 1).
//  Provides periodic and one-shot interrupts for OS ticks and delays.
// PARAMETERS
//  PRESCALE_RST  16'd0  reset value of PRESCALE register
//  RELOAD_RST    16'd0  reset value of RELOAD register
// PORTS
//  cpu_clk   in   1   CPU clock; all state changes on posedge
//  rst       in   1   synchronous, active-high reset
//  addr      in   20  bus address minus base; only [1:0] used when sel=1
//  sel       in   1   decoder select: addr_bus in 0x14..0x17 and ~ram_instr
//  write     in   1   write strobe (ram_write), qualified by sel
//  data_in   in   16  write data (ram_in)
//  data_out  out  16  read data, combinational from addr[1:0] and registers
//  irq       out  1   level interrupt = pending & ctrl.ie
//  tick      out  1   one-cycle pulse on every expiry
// BEHAVIOUR
//  Register map (addr[1:0]):
//   0 CTRL, read {pending,12'b0,ie,auto,en}.
//     Write bits[2:0] -> ctrl. Write bit15=1 clears pending (W1C).
//   1 RELOAD, R/W 16b.
//   2 COUNT, read live counter. Write loads the counter and clears pre_cnt.
//   3 PRESCALE, R/W 16b. Write clears pre_cnt.
//  Reset: ctrl=0, pending=0, count=0, pre_cnt=0.
//   RELOAD=RELOAD_RST, PRESCALE=PRESCALE_RST. irq=0, tick=0.
//   data_out reflects the reset registers.
//  Prescaler, when en=1 each cycle:
//   pre_cnt==PRESCALE -> pre_cnt<=0 and a step occurs.
//   Otherwise pre_cnt<=pre_cnt+1.
//   When en=0, pre_cnt and count hold.
//  Step:
//   count!=0 -> count<=count-1.
//   count==0 -> expiry: pending<=1, tick=1 for the next cycle.
//     auto=1: count<=RELOAD.
//     auto=0: en<=0, count stays 0.
//  Period with auto=1 is (RELOAD+1)*(PRESCALE+1) cycles between ticks.
//  Enable 0->1 write: pre_cnt<=0. The first step comes PRESCALE+1 cycles
//   after the write cycle.
//  Arithmetic is 16-bit unsigned. No wrap below 0; expiry handles the 0 case.
//  Simultaneous events:
//   CPU write to COUNT or PRESCALE in a step cycle: the write wins, no step.
//   W1C in an expiry cycle: the set wins, pending stays 1.
//   CTRL write en=0 in an expiry cycle: pending still sets, en ends at 0.
//   CTRL write during one-shot auto-disable: the written en value wins.
//  write with sel=0 is ignored. Reads have no side effects.
//  rst mid-count aborts immediately. irq drops the cycle after rst is sampled.
//  irq is level-held until W1C or ie=0.
// TESTING
//  1 Reset: rst 2 cycles -> all reads 0 (RELOAD/PRESCALE = params), irq=0.
//  2 Periodic: PRESCALE=1, RELOAD=3, COUNT=3, CTRL=7.
//    -> tick every 8 cycles; irq high after the first tick until CTRL<=16'h8007.
//  3 One-shot: PRESCALE=0, COUNT=2, CTRL=5.
//    -> single tick 3 cycles after the step start; CTRL reads 16'h8004; count stays 0.
//  4 Collision: write COUNT=9 in a step cycle -> COUNT reads 9, no decrement.
//    W1C in an expiry cycle -> pending stays 1.
//  5 Decode: write with sel=0 to each address -> no register change.
//    irq stays 0 while ie=0 even with pending=1.
//  6 Reset mid-run: assert rst during periodic operation
//    -> next cycle count=0, en=0, irq=0, tick=0.

Source files
------------

// File: rtl/bus_timer.sv
// bus_timer: 16-bit prescaled interval timer on the CPU data bus.
// CTRL/RELOAD/COUNT/PRESCALE map, W1C pending flag, level irq, tick pulse.
module bus_timer #(
  parameter logic [15:0] PRESCALE_RST = 16'd0,
  parameter logic [15:0] RELOAD_RST   = 16'd0
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic [19:0] addr,
  input  logic        sel,
  input  logic        write,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        irq,
  output logic        tick
);

  localparam logic [1:0] A_CTRL     = 2'd0;
  localparam logic [1:0] A_RELOAD   = 2'd1;
  localparam logic [1:0] A_COUNT    = 2'd2;
  localparam logic [1:0] A_PRESCALE = 2'd3;

  logic        en;
  logic        auto_rl;
  logic        ie;
  logic        pending;
  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] prescale;
  logic [15:0] pre_cnt;

  logic wr;
  logic wr_ctrl;
  logic wr_reload;
  logic wr_count;
  logic wr_pre;
  logic pre_hit;
  logic step;
  logic expire;
  logic en_rise;

  logic rd_ctrl;
  logic rd_reload;
  logic rd_count;
  logic rd_pre;

  logic addr_unused;
  assign addr_unused = ^addr[19:2];

  always_comb begin
    wr        = sel & write;
    wr_ctrl   = wr & (addr[1:0] == A_CTRL);
    wr_reload = wr & (addr[1:0] == A_RELOAD);
    wr_count  = wr & (addr[1:0] == A_COUNT);
    wr_pre    = wr & (addr[1:0] == A_PRESCALE);
    pre_hit   = (pre_cnt == prescale);
    // a CPU write to COUNT or PRESCALE pre-empts the step
    step      = en & pre_hit & ~wr_count & ~wr_pre;
    expire    = step & (count == 16'd0);
    en_rise   = wr_ctrl & data_in[0] & ~en;
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      pending  <= 1'b0;
      reload   <= RELOAD_RST;
      prescale <= PRESCALE_RST;
      count    <= 16'd0;
      pre_cnt  <= 16'd0;
      tick     <= 1'b0;
    end else begin
      tick <= expire;

      if (wr_ctrl) begin
        {ie, auto_rl, en} <= data_in[2:0];
      end else if (expire & ~auto_rl) begin
        en <= 1'b0;
      end

      if (expire) begin
        pending <= 1'b1;
      end else if (wr_ctrl & data_in[15]) begin
        pending <= 1'b0;
      end

      if (wr_reload) begin
        reload <= data_in;
      end

      if (wr_pre) begin
        prescale <= data_in;
      end

      if (wr_count) begin
        count <= data_in;
      end else if (step) begin
        if (count != 16'd0) begin
          count <= count - 16'd1;
        end else if (auto_rl) begin
          count <= reload;
        end
      end

      if (wr_count | wr_pre | en_rise) begin
        pre_cnt <= 16'd0;
      end else if (en) begin
        pre_cnt <= pre_hit ? 16'd0 : pre_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rd_ctrl   = (addr[1:0] == A_CTRL);
    rd_reload = (addr[1:0] == A_RELOAD);
    rd_count  = (addr[1:0] == A_COUNT);
    rd_pre    = (addr[1:0] == A_PRESCALE);
  end

  always_comb begin
    data_out = 16'd0;
    unique case (1'b1)
      rd_ctrl:   data_out = {pending, 12'd0, ie, auto_rl, en};
      rd_reload: data_out = reload;
      rd_count:  data_out = count;
      rd_pre:    data_out = prescale;
      default:   data_out = 16'd0;
    endcase
  end

  assign irq = pending & ie;

endmodule
